// File: rtl/cordic_atan.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_atan
//  Description : Iterative vectoring-mode CORDIC. It computes atan2(y,x) in
//                degrees and sqrt(x^2+y^2) from Q16.8 inputs, producing one
//                result every ITER+3 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_atan #(
    parameter int N    = 24,   // input width, signed Q16.8
    parameter int M    = 24,   // output width, signed Q16.8
    parameter int W    = 32,   // working width, Q16.16
    parameter int ITER = 16    // number of CORDIC iterations
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_start,
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_y,
    output logic [M-1:0] o_angle,
    output logic [M-1:0] o_mag,
    output logic         o_ovf,
    output logic         busy,
    output logic         done
);

    // The x/y datapath carries two guard bits above W. Without them, a
    // full-scale input pair grows by sqrt(2) * 1.647 and wraps during the
    // iterations.
    localparam int XW = W + 2;
    localparam int PW = 2 * W;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic signed [W-1:0]  c_deg90 = W'(90 * 65536);
    localparam logic signed [PW-1:0] c_k     = PW'(39797);   // 0.607253 in Q16.16

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PREROT = 3'd1,
        S_ITER   = 3'd2,
        S_SCALE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    logic signed [XW-1:0]  r_x;
    logic signed [XW-1:0]  r_y;
    logic signed [W-1:0]   r_z;
    logic [CW-1:0]         r_cnt;
    logic                  r_zero;

    logic signed [XW-1:0]  w_xs;
    logic signed [XW-1:0]  w_ys;
    logic signed [W-1:0]   w_t;
    logic signed [PW-1:0]  w_prod;
    logic signed [PW-1:0]  w_mag8;
    logic                  w_ovf;

    // This function returns round(atan(2^-i) * 65536) in degrees. Entries
    // beyond 15 use the small-angle approximation (180/pi) * 2^-i.
    function automatic logic signed [W-1:0] atan_entry(input logic [CW-1:0] idx);
        int v;
        case (int'(idx))
            0:  v = 2949120;
            1:  v = 1740967;
            2:  v = 919879;
            3:  v = 466945;
            4:  v = 234379;
            5:  v = 117304;
            6:  v = 58666;
            7:  v = 29335;
            8:  v = 14668;
            9:  v = 7334;
            10: v = 3667;
            11: v = 1833;
            12: v = 917;
            13: v = 458;
            14: v = 229;
            15: v = 115;
            default: v = (3754936 + (1 << (int'(idx) - 1))) >> int'(idx);
        endcase
        return W'(v);
    endfunction

    assign w_xs = r_x >>> r_cnt;
    assign w_ys = r_y >>> r_cnt;
    assign w_t  = atan_entry(r_cnt);

    // Magnitude: x * K in Q16.16, then dropping 8 more fraction bits gives
    // Q16.8. Truncation is by arithmetic shift.
    assign w_prod = $signed({{(PW-XW){r_x[XW-1]}}, r_x}) * c_k;
    assign w_mag8 = w_prod >>> 24;
    assign w_ovf  = |w_mag8[PW-1:M-1];

    // Sequencer and datapath: capture, quadrant fold, micro-rotations,
    // scaling, then a one-cycle done pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            o_angle <= '0;
            o_mag   <= '0;
            o_ovf   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_x     <= {{(XW-N-8){i_x[N-1]}}, i_x, 8'd0};
                        r_y     <= {{(XW-N-8){i_y[N-1]}}, i_y, 8'd0};
                        r_z     <= '0;
                        busy    <= 1'b1;
                        r_state <= S_PREROT;
                    end
                end
                S_PREROT: begin
                    // Fold the left half-plane into the right half-plane
                    // so that the iterations converge.
                    r_zero <= (r_x == '0) && (r_y == '0);
                    if (r_x[XW-1]) begin
                        if (!r_y[XW-1]) begin
                            r_x <= r_y;
                            r_y <= -r_x;
                            r_z <= c_deg90;
                        end else begin
                            r_x <= -r_y;
                            r_y <= r_x;
                            r_z <= -c_deg90;
                        end
                    end
                    r_cnt   <= '0;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    if (!r_y[XW-1]) begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + w_t;
                    end else begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - w_t;
                    end
                    if (r_cnt == CW'(ITER - 1)) begin
                        r_state <= S_SCALE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SCALE: begin
                    if (r_zero) begin
                        o_angle <= '0;
                        o_mag   <= '0;
                        o_ovf   <= 1'b0;
                    end else begin
                        o_angle <= M'(r_z >>> 8);
                        if (w_ovf) begin
                            o_mag <= {1'b0, {(M-1){1'b1}}};
                            o_ovf <= 1'b1;
                        end else begin
                            o_mag <= w_mag8[M-1:0];
                            o_ovf <= 1'b0;
                        end
                    end
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/cordic_atan.md
CORDIC_ATAN -- requirements
Module: cordic_atan

Interface
REQ-001 SHALL have parameter N, default 24, meaning signed input x/y width in Q16.8.
REQ-002 SHALL have parameter M, default 24, meaning signed output angle/magnitude width in Q16.8.
REQ-003 SHALL have parameter W, default 32, meaning internal working width in Q16.16.
REQ-004 SHALL have parameter ITER, default 16, meaning the number of CORDIC iterations.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port i_start, input, 1 bit: a request, sampled only in IDLE.
REQ-008 SHALL have ports i_x and i_y, input, N bits each: signed vector components in Q16.8.
REQ-009 SHALL have port o_angle, output, M bits: signed atan2(y,x) in degrees, Q16.8.
REQ-010 SHALL have port o_mag, output, M bits: signed sqrt(x²+y²), Q16.8, always non-negative.
REQ-011 SHALL have port o_ovf, output, 1 bit: o_mag saturated.
REQ-012 SHALL have port busy, output, 1 bit: high while the state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: a one-cycle result-valid pulse.

Function
REQ-014 SHALL implement the FSM states IDLE, PREROT, ITER, SCALE and DONE.
REQ-015 Transitions:
  - IDLE->PREROT on i_start=1, capturing i_x and i_y;
  - PREROT->ITER after 1 cycle;
  - ITER->SCALE after ITER cycles;
  - SCALE->DONE after 1 cycle;
  - DONE->IDLE after 1 cycle.
REQ-016 Capture SHALL sign-extend x and y to W bits and shift left 8 (Q16.8 to Q16.16); z (the angle accumulator, degrees Q16.16) SHALL be 0.
REQ-017 PREROT SHALL operate as follows:
  - x≥0: no change;
  - x<0 and y≥0: (x,y)←(y,−x), z←+90.0;
  - x<0 and y<0: (x,y)←(−y,x), z←−90.0.
REQ-018 PREROT SHALL set an internal zero flag when captured x=0 and y=0.
REQ-019 Iteration i (0..ITER−1) SHALL operate as follows:
  - y≥0: x←x+(y>>>i), y←y−(x>>>i), z←z+T[i];
  - else the opposite signs;
  - both updates use the pre-iteration x and y.
REQ-020 T[i] SHALL be round(atan(2^−i)·65536) in degrees, held in a constant table with ITER entries.
REQ-021 SCALE SHALL compute mag = (x·39797)>>>16, where 39797 is K≈0.607253 in Q16.16, using a 2W-bit product.
REQ-022 On entry to DONE, the following SHALL be registered:
  - o_angle = z[W−1:8];
  - o_mag = mag[W−1:8];
  - truncation, not rounding.
REQ-023 If mag exceeds 2^(M−1)−1 in Q16.8, o_mag SHALL be 0x7FFFFF and o_ovf SHALL be 1; otherwise o_ovf SHALL be 0.
REQ-024 If the zero flag is set, o_angle SHALL be 0 and o_mag SHALL be 0, overriding the CORDIC result.
REQ-025 o_angle range SHALL be (−180.0, +180.0]; x<0 with y=0 SHALL yield +180.0.
REQ-026 Latency: with i_start sampled at edge k, done SHALL be high in the cycle after edge k+18 and low after edge k+19.
REQ-027 busy SHALL be high from after edge k until after edge k+19.
REQ-028 done SHALL be high for exactly one cycle per accepted request.
REQ-029 i_start while busy=1 (including the DONE cycle) SHALL be ignored, not queued.
REQ-030 o_angle, o_mag and o_ovf SHALL hold their values until the next DONE entry.
REQ-031 Changes on i_x and i_y after capture SHALL NOT affect the result in progress.

Reset
REQ-032 While RST=0, asynchronously: state=IDLE; o_angle=0; o_mag=0; o_ovf=0; busy=0; done=0; x, y, z, iteration counter and zero flag cleared.
REQ-033 RST asserted mid-operation (any state) SHALL abort without producing a done pulse.
REQ-034 The first i_start after RST deassertion SHALL complete with normal latency.

Verification
REQ-035 Scenario: x=0x000100, y=0x000100, start -> done at 18 cycles, o_angle=0x002D00±3 LSB, o_mag=0x00016A±2 LSB, o_ovf=0.
REQ-036 Scenario: x=0xFFFF00 (−1.0), y=0 -> o_angle=0x00B400±3 (+180.0), o_mag=0x000100±2.
REQ-037 Scenario: x=0, y=0xFFFE00 (−2.0) -> o_angle=0xFFA600±3 (−90.0), o_mag=0x000200±2.
REQ-038 Scenario: x=0, y=0 -> o_angle=0x000000, o_mag=0x000000, done still at 18 cycles.
REQ-039 Scenario: x=y=0x7FFFFF -> o_mag=0x7FFFFF, o_ovf=1, o_angle=0x002D00±3.
REQ-040 Scenario: start, pulse i_start again at cycle 5, then RST=0 at cycle 10 -> second start ignored, outputs 0, busy=0, no done; a new start after reset completes correctly.
